branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve_pkg.sv | 34 +++
 rtl/branch_resolve_if.sv | 46 ++++
 rtl/branch_target_buffer.sv | 88 ++++++++
 rtl/branch_resolve.sv | 78 +++++++
 tb/tb_branch_resolve.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_pkg
// Description : Shared constants and helpers for branch resolution and the BTB.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_pkg;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_IDX_BITS = 6;

    // funct3 encodings seen by the EX comparator
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_if
// Description : Fetch-lookup, EX-resolution and redirect signals of the block.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_if
    import branch_resolve_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] if_pc;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;

    logic             ex_valid;
    logic             stall;
    logic             ex_is_branch;
    logic             ex_is_jal;
    logic             ex_is_jalr;
    logic [WIDTH-1:0] ex_pc;
    logic [WIDTH-1:0] ex_imm;
    logic [WIDTH-1:0] ex_rs1;
    logic             ex_pred_taken;
    logic [WIDTH-1:0] ex_pred_target;
    logic             comp;

    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             flush;

    modport master (
        output if_pc, ex_valid, stall, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_pc, ex_imm, ex_rs1, ex_pred_taken, ex_pred_target, comp,
        input  pred_taken, pred_target, redirect_valid, redirect_pc, flush
    );

    modport slave (
        input  if_pc, ex_valid, stall, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_pc, ex_imm, ex_rs1, ex_pred_taken, ex_pred_target, comp,
        output pred_taken, pred_target, redirect_valid, redirect_pc, flush
    );

endinterface
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer
// Description : Direct-mapped BTB with 2-bit counters; one read, one write port.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer
    import branch_resolve_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int IDX_BITS = DEFAULT_IDX_BITS
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] rd_pc,
    output logic                  rd_taken,
    output logic      [WIDTH-1:0] rd_target,
    input  wire logic             wr_en,
    input  wire logic [WIDTH-1:0] wr_pc,
    input  wire logic             wr_taken,
    input  wire logic             wr_jump,
    input  wire logic [WIDTH-1:0] wr_target
);

    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = WIDTH - IDX_BITS - 2;

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [1:0]          ctr_q [ENTRIES];
    logic [1:0]          ctr_d [ENTRIES];
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_d [ENTRIES];
    logic [WIDTH-1:0]    tgt_q [ENTRIES];
    logic [WIDTH-1:0]    tgt_d [ENTRIES];

    logic [IDX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_BITS-1:0] rd_tag, wr_tag;
    logic                wr_hit;
    logic                unused_pc_lsbs;

    assign rd_idx = rd_pc[IDX_BITS+1:2];
    assign rd_tag = rd_pc[WIDTH-1:IDX_BITS+2];
    assign wr_idx = wr_pc[IDX_BITS+1:2];
    assign wr_tag = wr_pc[WIDTH-1:IDX_BITS+2];
    assign unused_pc_lsbs = ^{rd_pc[1:0], wr_pc[1:0]};

    // Reads come straight from the registered arrays, so a same-cycle write is not visible.
    assign rd_taken  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && ctr_q[rd_idx][1];
    assign rd_target = tgt_q[rd_idx];
    assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (wr_en) begin
            if (wr_taken) begin
                valid_d[wr_idx] = 1'b1;
                tag_d[wr_idx]   = wr_tag;
                tgt_d[wr_idx]   = wr_target;
                ctr_d[wr_idx]   = wr_jump ? ST : ctr_inc(ctr_q[wr_idx]);
            end else if (wr_hit) begin
                // Not-taken on a miss must not train some other branch's entry.
                ctr_d[wr_idx] = ctr_dec(ctr_q[wr_idx]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : EX-stage branch resolution, one-cycle redirect/flush, BTB training.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int IDX_BITS = DEFAULT_IDX_BITS
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    branch_resolve_if.slave bus
);

    logic             redirect_valid_q, redirect_valid_d;
    logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    logic             res_en;
    logic             is_cf;
    logic             is_jump;
    logic             taken;
    logic             mispredict;
    logic [WIDTH-1:0] jalr_sum;
    logic [WIDTH-1:0] target;

    always_comb begin
        is_jump  = bus.ex_is_jal | bus.ex_is_jalr;
        is_cf    = bus.ex_is_branch | is_jump;
        taken    = is_jump | (bus.ex_is_branch & bus.comp);
        jalr_sum = bus.ex_rs1 + bus.ex_imm;
        target   = bus.ex_is_jalr ? {jalr_sum[WIDTH-1:1], 1'b0} : (bus.ex_pc + bus.ex_imm);
        mispredict = (taken != bus.ex_pred_taken)
                   | (taken & bus.ex_pred_taken & (target != bus.ex_pred_target));
        // The EX slot behind an outstanding redirect is wrong-path.
        res_en = bus.ex_valid & ~bus.stall & ~redirect_valid_q;

        redirect_valid_d = res_en & mispredict;
        redirect_pc_d    = redirect_pc_q;
        if (redirect_valid_d) begin
            redirect_pc_d = taken ? target : (bus.ex_pc + WIDTH'(4));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.flush          = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

    branch_target_buffer #(
        .WIDTH    (WIDTH),
        .IDX_BITS (IDX_BITS)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_pc     (bus.if_pc),
        .rd_taken  (bus.pred_taken),
        .rd_target (bus.pred_target),
        .wr_en     (res_en & is_cf),
        .wr_pc     (bus.ex_pc),
        .wr_taken  (taken),
        .wr_jump   (is_jump),
        .wr_target (target)
    );

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve
// Description : Directed + random bench for branch_resolve with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_branch_resolve;

    localparam int WIDTH    = 32;
    localparam int IDX_BITS = 6;
    localparam int ENTRIES  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    branch_resolve_if #(.WIDTH(WIDTH)) bus ();

    branch_resolve #(.WIDTH(WIDTH), .IDX_BITS(IDX_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: predictor table plus the expected redirect state
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    bit          m_rv;
    logic [31:0] m_rpc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_rv  = 1'b0;
        m_rpc = 32'h0;
    endtask

    task automatic model_step();
        bit          jump, cf, tk, res, mis, nrv;
        logic [31:0] tgt;
        int          i;
        jump = bus.ex_is_jal || bus.ex_is_jalr;
        cf   = jump || bus.ex_is_branch;
        tk   = jump || (bus.ex_is_branch && bus.comp);
        tgt  = bus.ex_is_jalr ? ((bus.ex_rs1 + bus.ex_imm) & ~32'h1) : (bus.ex_pc + bus.ex_imm);
        res  = bus.ex_valid && !bus.stall && !m_rv;
        mis  = (tk != bus.ex_pred_taken) || (tk && bus.ex_pred_taken && tgt != bus.ex_pred_target);
        nrv  = res && mis;
        if (nrv) m_rpc = tk ? tgt : bus.ex_pc + 32'd4;
        if (res && cf) begin
            i = idx_of(bus.ex_pc);
            if (tk) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = bus.ex_pc >> 8;
                m_tgt[i]   = tgt;
                m_ctr[i]   = jump ? 3 : ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3);
            end else if (m_valid[i] && m_tag[i] == (bus.ex_pc >> 8)) begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end
        m_rv = nrv;
    endtask

    // Compare process: checks every cycle, then advances the model to the next edge
    initial begin
        int  i;
        bit  exp_pt;
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            check("m_redirect_valid", bus.redirect_valid, m_rv);
            check("m_flush", bus.flush, m_rv);
            if (m_rv) check("m_redirect_pc", bus.redirect_pc, m_rpc);
            i = idx_of(bus.if_pc);
            exp_pt = m_valid[i] && (m_tag[i] == (bus.if_pc >> 8)) && (m_ctr[i] >= 2);
            check("m_pred_taken", bus.pred_taken, exp_pt);
            if (m_valid[i]) check("m_pred_target", bus.pred_target, m_tgt[i]);
            if (rst_n) model_step();
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ex_valid = 0; bus.stall = 0; bus.ex_is_branch = 0; bus.ex_is_jal = 0;
        bus.ex_is_jalr = 0; bus.ex_pc = 0; bus.ex_imm = 0; bus.ex_rs1 = 0;
        bus.ex_pred_taken = 0; bus.ex_pred_target = 0; bus.comp = 0;
    endtask

    task automatic drive(input bit br, input bit jal, input bit jalr, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1, input bit c,
                         input bit pt, input logic [31:0] ptgt);
        bus.ex_valid = 1; bus.stall = 0;
        bus.ex_is_branch = br; bus.ex_is_jal = jal; bus.ex_is_jalr = jalr;
        bus.ex_pc = pc; bus.ex_imm = imm; bus.ex_rs1 = rs1; bus.comp = c;
        bus.ex_pred_taken = pt; bus.ex_pred_target = ptgt;
    endtask

    initial begin
        logic [31:0] pc, imm, rs1;
        int          cls;
        idle();
        bus.if_pc = 32'h100;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_pred_taken", bus.pred_taken, 0);
        check("reset_redirect_valid", bus.redirect_valid, 0);
        check("reset_flush", bus.flush, 0);

        // Unpredicted taken branch
        next_cycle(); drive(1, 0, 0, 32'h100, 32'h40, 0, 1, 0, 0);
        @(negedge clk); check("br_latency_rv", bus.redirect_valid, 0);
        next_cycle(); idle();
        @(negedge clk);
        check("br_rv", bus.redirect_valid, 1);
        check("br_flush", bus.flush, 1);
        check("br_rpc", bus.redirect_pc, 32'h140);
        check("br_trained_pt", bus.pred_taken, 1);
        check("br_trained_tgt", bus.pred_target, 32'h140);
        next_cycle();
        @(negedge clk);
        check("br_pulse_end_rv", bus.redirect_valid, 0);
        check("br_pulse_end_flush", bus.flush, 0);

        // Predicted taken, actually not taken; same-index lookup sees old counter
        next_cycle(); drive(1, 0, 0, 32'h100, 32'h40, 0, 0, 1, 32'h140);
        @(negedge clk); check("same_idx_old_pt", bus.pred_taken, 1);
        next_cycle(); idle();
        @(negedge clk);
        check("nt_rv", bus.redirect_valid, 1);
        check("nt_rpc", bus.redirect_pc, 32'h104);
        check("nt_pt", bus.pred_taken, 0);
        for (int k = 0; k < 4; k++) begin
            next_cycle(); drive(1, 0, 0, 32'h100, 32'h40, 0, 0, 0, 0);
            @(negedge clk); check("nt_loop_rv", bus.redirect_valid, 0);
        end
        next_cycle(); drive(1, 0, 0, 32'h100, 32'h40, 0, 1, 0, 0);
        next_cycle(); idle();
        @(negedge clk); check("floor_ctr1_pt", bus.pred_taken, 0);
        next_cycle(); drive(1, 0, 0, 32'h100, 32'h40, 0, 1, 1, 32'h140);
        next_cycle(); idle();
        @(negedge clk); check("floor_ctr2_pt", bus.pred_taken, 1);

        // jalr with bit 0 cleared, correctly predicted
        next_cycle(); drive(0, 0, 1, 32'h200, 32'h10, 32'h2001, 0, 1, 32'h2010);
        bus.if_pc = 32'h200;
        next_cycle(); idle();
        @(negedge clk);
        check("jalr_rv", bus.redirect_valid, 0);
        check("jalr_pt", bus.pred_taken, 1);
        check("jalr_tgt", bus.pred_target, 32'h2010);
        next_cycle(); drive(1, 0, 0, 32'h200, 32'h10, 0, 0, 0, 0);
        next_cycle(); idle();
        @(negedge clk); check("jalr_ctr3_pt", bus.pred_taken, 1);

        // Wrap-around target, then a mispredict in the redirect cycle
        next_cycle(); drive(1, 0, 0, 32'hFFFF_FFF0, 32'h20, 0, 1, 0, 0);
        next_cycle(); drive(0, 1, 0, 32'h300, 32'h8, 0, 0, 0, 0);
        bus.if_pc = 32'h300;
        @(negedge clk);
        check("wrap_rv", bus.redirect_valid, 1);
        check("wrap_rpc", bus.redirect_pc, 32'h10);
        next_cycle(); idle();
        @(negedge clk);
        check("no_second_pulse", bus.redirect_valid, 0);
        check("wrongpath_no_alloc", bus.pred_taken, 0);

        // Reset in the middle of a redirect pulse
        next_cycle(); drive(1, 0, 0, 32'h400, 32'h40, 0, 1, 0, 0);
        next_cycle(); idle();
        bus.if_pc = 32'h200;
        @(negedge clk); check("pre_reset_rv", bus.redirect_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_rv", bus.redirect_valid, 0);
        check("async_reset_flush", bus.flush, 0);
        next_cycle(); rst_n = 1'b1;
        @(negedge clk); check("post_reset_pt", bus.pred_taken, 0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            pc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 7) == 0) pc = pc | 32'hFFFF_F000;
            imm = 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
            rs1 = $urandom;
            cls = int'($urandom_range(0, 3));
            bus.ex_valid     = ($urandom_range(0, 9) < 7);
            bus.stall        = ($urandom_range(0, 3) == 0);
            bus.ex_is_branch = (cls == 1);
            bus.ex_is_jal    = (cls == 2);
            bus.ex_is_jalr   = (cls == 3);
            bus.ex_pc        = pc;
            bus.ex_imm       = imm;
            bus.ex_rs1       = rs1;
            bus.comp         = $urandom_range(0, 1) == 1;
            bus.ex_pred_taken = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 2))
                0:       bus.ex_pred_target = pc + imm;
                1:       bus.ex_pred_target = (rs1 + imm) & ~32'h1;
                default: bus.ex_pred_target = $urandom;
            endcase
            bus.if_pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
        end
        next_cycle(); idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
